// File: rtl/add16_arbiter.sv
// add16_arbiter: round-robin sharing of one combinational 16-bit adder among
// N requesters. One operation is held in a registered result slot, tagged with
// the requester ID and a signed-overflow flag. Back-to-back accepts give
// 1 op/cycle when the consumer keeps resp_ready high.
module add16_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [16*N-1:0]   req_a,
  input  logic [16*N-1:0]   req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [15:0]       resp_sum,
  output logic              resp_ovf
);

  localparam int DATA_W = 16;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic        [IDW-1:0]     ptr_q, ptr_d;
  logic        [IDW-1:0]     id_q, id_d;
  logic signed [DATA_W-1:0]  sum_q, sum_d;
  logic                      ovf_q, ovf_d;

  logic                      found;
  logic        [IDW-1:0]     gnt;
  logic        [N-1:0]       gnt_oh;
  logic signed [DATA_W-1:0]  a_sel, b_sel, add_res;
  logic                      can_accept, accept;

  // Signed overflow: operands agree in sign but the wrapped sum does not.
  function automatic logic ovf16(input logic signed [DATA_W-1:0] a,
                                 input logic signed [DATA_W-1:0] b,
                                 input logic signed [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  // Round-robin grant: pick the valid requester closest to ptr going upward.
  always_comb begin
    int best_d;
    int d;
    best_d = N;
    d      = 0;
    gnt    = '0;
    gnt_oh = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < N; i++) begin
      d = i - int'(ptr_q);
      if (d < 0) d = d + N;
      if (req_valid[i] && (d < best_d)) begin
        best_d    = d;
        gnt       = IDW'(i);
        gnt_oh    = '0;
        gnt_oh[i] = 1'b1;
        a_sel     = req_a[DATA_W*i +: DATA_W];
        b_sel     = req_b[DATA_W*i +: DATA_W];
      end
    end
    found = (best_d < N);
  end

  // The slot can take a new op when empty or when its result leaves this cycle.
  always_comb begin
    add_res    = a_sel + b_sel;
    can_accept = (state_q == IDLE) || resp_ready;
    accept     = found && can_accept && !reset;
    req_ready  = accept ? gnt_oh : '0;
  end

  // Next-state: load on accept, drain on consumer ready, otherwise hold.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    if (accept) begin
      state_d = HOLD;
      ptr_d   = (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
      id_d    = gnt;
      sum_d   = add_res;
      ovf_d   = ovf16(a_sel, b_sel, add_res);
    end else if ((state_q == HOLD) && resp_ready) begin
      state_d = IDLE;
    end
  end

  // Result register and arbitration pointer; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign resp_valid = (state_q == HOLD);
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;
  assign resp_ovf   = ovf_q;

endmodule

// File: tb/tb_add16_arbiter.sv
// Bench for add16_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_add16_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_a, req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [IDW-1:0]  resp_id;
  logic [15:0]     resp_sum;
  logic            resp_ovf;

  logic [15:0]     a_arr [N];
  logic [15:0]     b_arr [N];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_ptr;
  logic        m_valid;
  logic [15:0] m_sum;
  int          m_id;
  logic        m_ovf;

  add16_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_sum  (resp_sum),
    .resp_ovf  (resp_ovf)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = a_arr[i];
      req_b[16*i +: 16] = b_arr[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One clock: check combinational ready, clock the DUT, update model, check outputs.
  task automatic cycle();
    int g;
    int sa, sb, s;
    logic [N-1:0] er;
    #1;
    g  = model_grant(req_valid, m_ptr);
    er = '0;
    if (g >= 0 && !reset && (!m_valid || resp_ready)) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_sum = 0; m_id = 0; m_ovf = 0; m_ptr = 0;
    end else if (er != '0) begin
      sa      = int'($signed(a_arr[g]));
      sb      = int'($signed(b_arr[g]));
      s       = sa + sb;
      m_sum   = 16'((a_arr[g] + b_arr[g]) & 32'hffff);
      m_ovf   = (s > 32767) || (s < -32768);
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % N;
    end else if (resp_ready) begin
      m_valid = 0;
    end
    #1;
    chk("resp_valid", 32'(resp_valid), 32'(m_valid));
    chk("resp_sum",   32'(resp_sum),   32'(m_sum));
    chk("resp_id",    32'(resp_id),    32'(m_id));
    chk("resp_ovf",   32'(resp_ovf),   32'(m_ovf));
  endtask

  initial begin
    reset = 1; req_valid = '1; resp_ready = 1;
    for (int i = 0; i < N; i++) begin a_arr[i] = 16'h0; b_arr[i] = 16'h0; end
    m_ptr = 0; m_valid = 0; m_sum = 0; m_id = 0; m_ovf = 0;

    // Reset: no grants while reset is high, outputs cleared
    cycle(); cycle();
    chk("reset_valid", 32'(resp_valid), 32'h0);
    chk("reset_sum",   32'(resp_sum),   32'h0);

    // Single request on requester 0
    reset = 0; req_valid = 4'b0001; a_arr[0] = 16'h0001; b_arr[0] = 16'h1080;
    cycle();
    chk("single_sum", 32'(resp_sum), 32'h1081);
    chk("single_id",  32'(resp_id),  32'h0);

    // Signed cases on requester 2
    req_valid = 4'b0100;
    a_arr[2] = 16'ha211; b_arr[2] = 16'h0730; cycle();
    chk("s1_sum", 32'(resp_sum), 32'ha941); chk("s1_ovf", 32'(resp_ovf), 32'h0);
    a_arr[2] = 16'h8001; b_arr[2] = 16'h8003; cycle();
    chk("s2_sum", 32'(resp_sum), 32'h0004); chk("s2_ovf", 32'(resp_ovf), 32'h1);
    a_arr[2] = 16'h0001; b_arr[2] = 16'hfffb; cycle();
    chk("s3_sum", 32'(resp_sum), 32'hfffc); chk("s3_ovf", 32'(resp_ovf), 32'h0);

    // Round robin from ptr=0 with all requesters active
    reset = 1; req_valid = '0; cycle();
    reset = 0; req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = 16'(16'h1111 * (i + 1)); b_arr[i] = 16'(16'h0101 << i);
    end
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_id",    32'(resp_id),    32'(k % N));
      chk("rr_valid", 32'(resp_valid), 32'h1);
    end

    // Backpressure: result held, no grants
    resp_ready = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_id",    32'(resp_id),    32'h0);
      chk("bp_ready", 32'(req_ready),  32'h0);
    end
    resp_ready = 1; cycle();
    chk("bp_release_id", 32'(resp_id), 32'h1);

    // Pointer skip: ptr=1, requesters 0 and 3
    reset = 1; req_valid = '0; cycle();
    reset = 0; req_valid = 4'b0001; cycle();
    req_valid = 4'b1001; cycle();
    chk("skip_first", 32'(resp_id), 32'h3);
    cycle();
    chk("skip_second", 32'(resp_id), 32'h0);

    // Reset while holding a result
    req_valid = 4'b0010; cycle();
    resp_ready = 0; req_valid = 4'b1111; reset = 1; cycle();
    chk("rst_hold_valid", 32'(resp_valid), 32'h0);
    chk("rst_hold_sum",   32'(resp_sum),   32'h0);
    reset = 0; resp_ready = 1; cycle();
    chk("rst_hold_grant", 32'(resp_id), 32'h0);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      req_valid  = N'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++) begin
        a_arr[i] = 16'($urandom); b_arr[i] = 16'($urandom);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/add16_arbiter.md
Name: add16_arbiter

Overview:
- Shares one Add16 16-bit adder among N requesters using a round-robin grant and per-requester valid/ready handshakes.
- Holds one operation in flight. The sum is registered and presented on a single response channel tagged with the requester ID, plus a signed-overflow flag.
- Sits between ALU-side clients and the adder; the adder remains purely combinational underneath.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2^IDW >= N.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  N  bit i: requester i presents an operand pair.
- req_ready  output  N  bit i: requester i is granted and accepted this cycle when req_valid[i] is also 1.
- req_a  input  16*N  operand A; requester i uses bits [16i+15:16i].
- req_b  input  16*N  operand B; same packing as req_a.
- resp_valid  output  1  result register holds an unconsumed result.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  IDW  index of the requester that produced the result.
- resp_sum  output  16  a+b modulo 2^16 (Add16 output, carry discarded).
- resp_ovf  output  1  signed overflow: sign(a)==sign(b) and sign(sum)!=sign(a).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values: resp_valid=0, resp_id=0, resp_sum=0, resp_ovf=0, priority pointer ptr=0, state=IDLE. req_ready is all-zero while reset=1.
- States:
  - IDLE: result register is empty.
  - HOLD: resp_valid=1 and the result is waiting for resp_ready.
- Grant (combinational):
  - Scan i = ptr, ptr+1, ..., wrapping mod N. The first i with req_valid[i]=1 is the grant g.
  - At most one bit of req_ready is set: req_ready[g] = (state==IDLE) or resp_ready.
  - No valid requests means req_ready=0.
- Accept (req_valid[g] and req_ready[g] at a clock edge):
  - Latch Add16(a_g, b_g) into resp_sum, g into resp_id, and ovf into resp_ovf.
  - resp_valid=1 on the next cycle, so latency is 1 cycle from acceptance.
  - ptr <= (g+1) mod N; state -> HOLD.
- HOLD and resp_ready=1 with no accept that cycle: resp_valid <- 0, state -> IDLE. resp_sum/id/ovf hold their last values.
- HOLD and resp_ready=1 with an accept in the same cycle: the result register reloads, resp_valid stays 1, state stays HOLD. This gives a throughput of 1 op/cycle.
- HOLD and resp_ready=0: resp_valid, resp_sum, resp_id and resp_ovf are held stable, and req_ready=0.
- ptr changes only on acceptance. Idle cycles do not advance it.
- Requester-side rule: once req_valid[i] is asserted it must stay asserted with stable operands until the accept cycle. The arbiter does not check this.
- Arithmetic is two's complement and wraps. Example: 0x8001+0x8003 = 0x0004 with resp_ovf=1.
- Reset mid-operation: a pending result is discarded (resp_valid=0 next cycle) and ptr returns to 0. Any request asserted during reset is not accepted.
- Bits of req_valid at index >= N do not exist. A grant index is always < N.

Test Plan:
- Single request (N=4):
  - Stimulus: req_valid=0001, a=0x0001, b=0x1080, resp_ready=1.
  - Response: req_ready=0001 in the same cycle; next cycle resp_valid=1, resp_sum=0x1081, resp_id=0, resp_ovf=0.
- Signed cases on requester 2:
  - a=0xa211, b=0x0730 -> resp_sum=0xa941, ovf=0.
  - a=0x8001, b=0x8003 -> resp_sum=0x0004, ovf=1.
  - a=0x0001, b=0xfffb -> resp_sum=0xfffc, ovf=0.
- Round robin:
  - Stimulus: req_valid=1111 held, resp_ready=1, each requester with distinct operands.
  - Response: resp_id sequence 0,1,2,3,0 on consecutive cycles, and resp_valid stays 1 throughout.
- Backpressure:
  - Stimulus: resp_ready=0 after the first accept.
  - Response: req_ready=0000; resp_sum/id/ovf stay stable for 5 cycles. Raising resp_ready gives acceptance of the next request in that same cycle.
- Pointer skip:
  - Stimulus: with ptr=1, req_valid=1001.
  - Response: grant to 3, then ptr=0, and the next grant goes to 0.
- Reset mid-HOLD:
  - Stimulus: assert reset for 1 cycle while resp_valid=1 and resp_ready=0.
  - Response: resp_valid=0 and resp_sum=0 the next cycle; with req_valid=1111 after release, the first grant goes to 0.
